regfile_wb: RTL

- Architectural 32x32 general-purpose register file for the five-stage pipeline.
- Responder side of the ID-stage register-read interface: ID drives the rs/rt addresses and this block returns the data.
- Accepts the WB-stage write port.
- Includes a debug dump sequencer that streams all registers over a valid/ready handshake to the board display/UART logic.

---
 rtl/regfile_wb.sv | 117 +++++++++++
 1 files changed

// File: rtl/regfile_wb.sv
// 32x32 architectural register file: two bypassed combinational read ports, one WB write port,
// and a valid/ready dump sequencer that streams every register to the debug display/UART logic.
module regfile_wb #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DUMP_LAST  = 31
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4:0]            RegAdd_rs,
   input  logic [4:0]            RegAdd_rt,
   output logic [DATA_WIDTH-1:0] RegData_rs,
   output logic [DATA_WIDTH-1:0] RegData_rt,
   input  logic                  WB_RegWrite,
   input  logic [4:0]            WB_RegAdd,
   input  logic [DATA_WIDTH-1:0] WB_RegData,
   input  logic                  Dump_Start,
   input  logic                  Dump_Ready,
   output logic                  Dump_Valid,
   output logic [4:0]            Dump_Index,
   output logic [DATA_WIDTH-1:0] Dump_Data,
   output logic                  Dump_Busy,
   output logic                  Dump_Done
);

   localparam int unsigned ADDR_WIDTH = 5;
   localparam int unsigned NUM_REGS   = 32;

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

   state_t                  state, state_nx;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
   logic [ADDR_WIDTH-1:0]   index_nx;
   logic [DATA_WIDTH-1:0]   data_nx;
   logic                    valid_nx;

   // Register array; r0 is never written and is forced to zero on every read path.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      end else if (WB_RegWrite && (WB_RegAdd != '0)) begin
         regs[WB_RegAdd] <= WB_RegData;
      end
   end

   // Write-first bypass so a WB result is visible to ID in the same cycle.
   always_comb begin
      RegData_rs = regs[RegAdd_rs];
      if (RegAdd_rs == '0)
         RegData_rs = '0;
      else if (WB_RegWrite && (WB_RegAdd == RegAdd_rs))
         RegData_rs = WB_RegData;
   end

   always_comb begin
      RegData_rt = regs[RegAdd_rt];
      if (RegAdd_rt == '0)
         RegData_rt = '0;
      else if (WB_RegWrite && (WB_RegAdd == RegAdd_rt))
         RegData_rt = WB_RegData;
   end

   // Dump sequencer state and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         Dump_Index <= '0;
         Dump_Data  <= '0;
         Dump_Valid <= 1'b0;
      end else begin
         state      <= state_nx;
         Dump_Index <= index_nx;
         Dump_Data  <= data_nx;
         Dump_Valid <= valid_nx;
      end
   end

   // Next-state logic; LOAD reads stored contents only, without the WB bypass.
   always_comb begin
      state_nx = state;
      index_nx = Dump_Index;
      data_nx  = Dump_Data;
      valid_nx = Dump_Valid;
      case (state)
         IDLE: begin
            if (Dump_Start) begin
               index_nx = '0;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            data_nx  = (Dump_Index == '0) ? '0 : regs[Dump_Index];
            valid_nx = 1'b1;
            state_nx = SEND;
         end
         SEND: begin
            if (Dump_Ready) begin
               valid_nx = 1'b0;
               if (Dump_Index == ADDR_WIDTH'(DUMP_LAST)) begin
                  state_nx = DONE;
               end else begin
                  index_nx = ADDR_WIDTH'(Dump_Index + 1'b1);
                  state_nx = LOAD;
               end
            end
         end
         DONE: begin
            index_nx = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign Dump_Busy = (state != IDLE);
   assign Dump_Done = (state == DONE);

endmodule
